// File: rtl/mcycle_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package mcycle_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mcycle_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } mcycle_state_e;

endpackage

// File: rtl/mcycle_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on a {hi, lo} register.
module mcycle_step
    import mcycle_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   pr,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   pr_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] diff;

    always_comb begin
        // Multiply: low half holds the remaining multiplier bits, product shifts in from the top.
        sum  = {1'b0, pr[2*WIDTH-1:WIDTH]} + (pr[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
        // Divide: trial-subtract the divisor from the remainder shifted left by one.
        diff = {1'b0, pr[2*WIDTH-1:WIDTH-1]} - {2'b00, b};
        pr_nxt = {sum, pr[WIDTH-1:1]};
        if (is_div) begin
            if (diff[WIDTH+1:WIDTH] != 2'b00)
                pr_nxt = {pr[2*WIDTH-2:0], 1'b0};
            else
                pr_nxt = {diff[WIDTH-1:0], pr[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mcycle_unit.sv
// Iterative RV32M multiply/divide: WIDTH compute cycles after the start cycle, Result/Done on the next.
// Busy stalls the pipeline while working; Abort or RESET drops the operation without a Done.
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [2:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    input  logic             Abort,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);

    mcycle_state_e      state;
    mcycle_op_e         op_q;
    mcycle_op_e         op_in;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] pr_q;
    logic [2*WIDTH-1:0] pr_nxt;
    logic [WIDTH-1:0]   b_q;
    logic               neg_q;
    logic               divz_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;

    logic               s1, s2, n1, n2, neg_in;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, final_res;

    assign op_in = mcycle_op_e'(MCycleOp);

    always_comb begin
        s1     = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                 (op_in == OP_DIV) || (op_in == OP_REM);
        s2     = (op_in == OP_MUL) || (op_in == OP_MULH) ||
                 (op_in == OP_DIV) || (op_in == OP_REM);
        n1     = s1 & Operand1[WIDTH-1];
        n2     = s2 & Operand2[WIDTH-1];
        mag1   = n1 ? -Operand1 : Operand1;
        mag2   = n2 ? -Operand2 : Operand2;
        // The remainder takes the dividend's sign; everything else takes the XOR of both.
        neg_in = (op_in == OP_REM) ? n1 : (n1 ^ n2);
    end

    mcycle_step #(.WIDTH(WIDTH)) u_step (
        .is_div (op_q[2]),
        .pr     (pr_q),
        .b      (b_q),
        .pr_nxt (pr_nxt)
    );

    always_comb begin
        prod = neg_q ? -pr_nxt : pr_nxt;
        quo  = neg_q ? -pr_nxt[WIDTH-1:0] : pr_nxt[WIDTH-1:0];
        rem  = neg_q ? -pr_nxt[2*WIDTH-1:WIDTH] : pr_nxt[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:                  final_res = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                final_res = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:         final_res = divz_q ? {WIDTH{1'b1}} : quo;
            default:                 final_res = rem;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt      <= '0;
            pr_q     <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            divz_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (Abort) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        state  <= ST_COMPUTE;
                        op_q   <= op_in;
                        cnt    <= '0;
                        pr_q   <= {{WIDTH{1'b0}}, mag1};
                        b_q    <= mag2;
                        neg_q  <= neg_in;
                        divz_q <= (Operand2 == '0);
                    end
                end
                ST_COMPUTE: begin
                    pr_q <= pr_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        state    <= ST_DONE;
                        result_q <= final_res;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign Result = result_q;
    assign Done   = done_q & ~Abort;
    assign Busy   = ~RESET & ~Abort &
                    (((state == ST_IDLE) & Start) | (state == ST_COMPUTE));

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed bench for mcycle_unit: result table plus abort/reset/start corner sequences.
module tb_mcycle_unit;
    import mcycle_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET, Start, Abort;
    logic [2:0]  MCycleOp;
    logic [31:0] Operand1, Operand2, Result;
    logic        Busy, Done;

    int pass_cnt = 0;
    int total    = 0;

    mcycle_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2), .Abort(Abort),
        .Result(Result), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, got, exp);
    endtask

    // Issues one instruction with Start held through DONE, dropped one cycle after Done.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int busy_n, output int done_n,
                         output int done_at);
        @(negedge CLK);
        MCycleOp = op; Operand1 = a; Operand2 = b; Start = 1'b1;
        busy_n = 0; done_n = 0; done_at = 0; res = Result;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (Busy) busy_n++;
            if (Done) begin done_n++; done_at = c; res = Result; end
            @(negedge CLK);
            if (done_n != 0) Start = 1'b0;
        end
        Start = 1'b0;
    endtask

    task automatic count_done(input int cycles, output int done_n, output int busy_n);
        done_n = 0; busy_n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLK); #1;
            if (Done) done_n++;
            if (Busy) busy_n++;
        end
    endtask

    initial begin
        logic [31:0] res, prev;
        int busy_n, done_n, done_at;

        vecs[0]  = '{"mul_7_m3",     OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1]  = '{"mulhu_m1_m1",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[2]  = '{"mulh_m1_m1",   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[3]  = '{"mulhsu_m1_m1", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4]  = '{"div_m7_2",     OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
        vecs[5]  = '{"rem_m7_2",     OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
        vecs[6]  = '{"divu_100_7",   OP_DIVU,   32'd100,      32'd7,        32'd14};
        vecs[7]  = '{"remu_100_7",   OP_REMU,   32'd100,      32'd7,        32'd2};
        vecs[8]  = '{"divu_5_0",     OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF};
        vecs[9]  = '{"remu_5_0",     OP_REMU,   32'd5,        32'd0,        32'd5};
        vecs[10] = '{"div_ovf",      OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{"rem_ovf",      OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[12] = '{"mul_lo",       OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780};
        vecs[13] = '{"mulh_min_min", OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
        vecs[14] = '{"mulhsu_min_2", OP_MULHSU, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};
        vecs[15] = '{"div_7_m2",     OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD};
        vecs[16] = '{"rem_7_m2",     OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001};
        vecs[17] = '{"div_m7_0",     OP_DIV,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF};
        vecs[18] = '{"rem_m7_0",     OP_REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9};
        vecs[19] = '{"remu_min_m1",  OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000};

        // Reset overrides Start and Abort; Busy must stay low throughout.
        RESET = 1'b1; Start = 1'b1; Abort = 1'b1; MCycleOp = 3'b000;
        Operand1 = 32'd3; Operand2 = 32'd4;
        @(negedge CLK); @(negedge CLK); #1;
        chk("rst_busy_abort", {31'd0, Busy}, 32'd0);
        Abort = 1'b0; #1;
        chk("rst_busy_start", {31'd0, Busy}, 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0; Start = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, busy_n, done_n, done_at);
            chk({vecs[i].name, "_res"}, res, vecs[i].exp);
            chk({vecs[i].name, "_busy"}, busy_n, 33);
            chk({vecs[i].name, "_ndone"}, done_n, 1);
            chk({vecs[i].name, "_lat"}, done_at, 34);
        end
        prev = vecs[19].exp;

        // Start together with Abort in IDLE must not begin an operation.
        @(negedge CLK);
        MCycleOp = OP_DIVU; Operand1 = 32'd9; Operand2 = 32'd3; Start = 1'b1; Abort = 1'b1; #1;
        chk("startabort_busy", {31'd0, Busy}, 32'd0);
        @(negedge CLK);
        Start = 1'b0; Abort = 1'b0;
        count_done(40, done_n, busy_n);
        chk("startabort_ndone", done_n, 0);
        chk("startabort_nbusy", busy_n, 0);

        // Abort in COMPUTE cycle 10 (cycle 11 counting the start cycle).
        @(negedge CLK);
        MCycleOp = OP_DIV; Operand1 = 32'd100; Operand2 = 32'd7; Start = 1'b1;
        for (int c = 1; c < 11; c++) @(negedge CLK);
        #1;
        chk("abort_busy_pre", {31'd0, Busy}, 32'd1);
        Abort = 1'b1; #1;
        chk("abort_busy_same", {31'd0, Busy}, 32'd0);
        @(negedge CLK);
        Abort = 1'b0; Start = 1'b0; #1;
        chk("abort_busy_next", {31'd0, Busy}, 32'd0);
        count_done(40, done_n, busy_n);
        chk("abort_ndone", done_n, 0);
        chk("abort_result_hold", Result, prev);
        do_op(OP_DIV, 32'd100, 32'd7, res, busy_n, done_n, done_at);
        chk("after_abort_res", res, 32'd14);
        chk("after_abort_lat", done_at, 34);
        chk("after_abort_ndone", done_n, 1);

        // Reset in COMPUTE cycle 20 discards the operation and clears Result.
        @(negedge CLK);
        MCycleOp = OP_MUL; Operand1 = 32'd7; Operand2 = 32'hFFFFFFFD; Start = 1'b1;
        for (int c = 1; c < 21; c++) @(negedge CLK);
        RESET = 1'b1; #1;
        chk("midrst_busy", {31'd0, Busy}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0; Start = 1'b0; #1;
        chk("midrst_result", Result, 32'd0);
        chk("midrst_idle_busy", {31'd0, Busy}, 32'd0);
        count_done(40, done_n, busy_n);
        chk("midrst_ndone", done_n, 0);
        do_op(OP_REMU, 32'd100, 32'd7, res, busy_n, done_n, done_at);
        chk("after_rst_res", res, 32'd2);
        chk("after_rst_busy", busy_n, 33);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
